// File: rtl/softrc_freq_meter.sv
// softrc_freq_meter: starts the soft RC ring oscillator, lets it settle,
// counts its rising edges over a window of clk_i cycles, stops the ring, and
// offers the count to the power-management controller on a valid/ready
// handshake.
module softrc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] win_len_i,
  output logic             pd_rc_o,
  input  logic             rc_osc_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             cnt_valid_o,
  input  logic             cnt_ready_i
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  logic             pd_q, pd_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [CNT_W:0]   inc_res;

  // Saturating increment: MSB of the result flags an edge lost at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return {1'b1, c};
    end
    return {1'b0, c + CNT_W'(1)};
  endfunction

  // Synchroniser and edge history; reset to 1 so a stopped (high) ring
  // and its first falling transition never look like a rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rc_osc_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Next-state and next-output logic of the measurement sequencer.
  always_comb begin
    state_d = state_q;
    pd_d    = pd_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    win_d   = win_q;
    sc_d    = sc_q;
    inc_res = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          win_d   = win_len_i;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          pd_d    = 1'b0;
          busy_d  = 1'b1;
          sc_d    = SC_LOAD;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (abort_i) begin
          pd_d    = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (sc_q == '0) begin
          if (win_q != '0) begin
            state_d = S_COUNT;
          end else begin
            pd_d    = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          sc_d = sc_q - SC_W'(1);
        end
      end

      S_COUNT: begin
        if (abort_i) begin
          pd_d    = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (rise) begin
            inc_res = sat_inc(cnt_q);
            cnt_d   = inc_res[CNT_W-1:0];
            if (inc_res[CNT_W]) begin
              ovf_d = 1'b1;
            end
          end
          win_d = win_q - WIN_W'(1);
          if (win_q == WIN_W'(1)) begin
            pd_d    = 1'b1;
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (abort_i) begin
          pd_d    = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (valid_q && cnt_ready_i) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        pd_d    = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset stops the ring immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pd_q    <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pd_q    <= pd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Window and settle counters are always loaded before they are used.
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
    sc_q  <= sc_d;
  end

  assign pd_rc_o     = pd_q;
  assign busy_o      = busy_q;
  assign cnt_valid_o = valid_q;
  assign cnt_o       = cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_softrc_freq_meter.sv
// Directed bench for softrc_freq_meter: clock period 50 units, ring model
// period 500 units (ten clk cycles per ring period) that is held high while
// the ring is powered down.
module tb_softrc_freq_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic        abort;
  logic [15:0] win_len;
  logic        ready, ready4;
  logic        ring_ph = 1'b0;

  logic        pd, busy, vld, ovf;
  logic [15:0] cnt;
  logic        pd4, busy4, vld4, ovf4;
  logic [3:0]  cnt4;
  logic        rc, rc4;

  int tests = 0;
  int fails = 0;

  always #25 clk = ~clk;
  always #250 ring_ph = ~ring_ph;

  assign rc  = pd  ? 1'b1 : ring_ph;
  assign rc4 = pd4 ? 1'b1 : ring_ph;

  softrc_freq_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .win_len_i(win_len), .pd_rc_o(pd), .rc_osc_i(rc), .busy_o(busy),
    .cnt_o(cnt), .ovf_o(ovf), .cnt_valid_o(vld), .cnt_ready_i(ready)
  );

  softrc_freq_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(abort),
    .win_len_i(win_len), .pd_rc_o(pd4), .rc_osc_i(rc4), .busy_o(busy4),
    .cnt_o(cnt4), .ovf_o(ovf4), .cnt_valid_o(vld4), .cnt_ready_i(ready4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; abort = 1'b0;
    win_len = 16'd0; ready = 1'b1; ready4 = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_pd", pd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_cnt", cnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_vld", vld, 0);
    chk("idle_pd", pd, 1);

    // win_len=100: valid exactly at T+109, pd low T+1..T+108
    win_len = 16'd100; start = 1'b1;
    for (int n = 1; n <= 109; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      chk("w100_pd", pd, (n == 109) ? 1 : 0);
      chk("w100_vld", vld, (n == 109) ? 1 : 0);
    end
    chk("w100_cnt_range", (cnt >= 16'd9 && cnt <= 16'd11) ? 1 : 0, 1);
    chk("w100_ovf", ovf, 0);
    tick();
    chk("w100_vld_drop", vld, 0);
    chk("w100_busy_drop", busy, 0);

    // win_len=0, started the cycle after valid dropped
    win_len = 16'd0; start = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 1) begin
        start = 1'b0;
        chk("w0_busy", busy, 1);
      end
      chk("w0_vld", vld, (n == 9) ? 1 : 0);
    end
    chk("w0_cnt", cnt, 0);
    chk("w0_ovf", ovf, 0);
    chk("w0_pd", pd, 1);
    tick();
    chk("w0_vld_drop", vld, 0);

    // CNT_W=4 saturation, result held under back-pressure
    win_len = 16'd400; start4 = 1'b1; ready4 = 1'b0;
    for (int n = 1; n <= 409; n++) begin
      tick();
      if (n == 1) start4 = 1'b0;
    end
    chk("sat_vld", vld4, 1);
    chk("sat_cnt", cnt4, 15);
    chk("sat_ovf", ovf4, 1);
    chk("sat_pd", pd4, 1);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("sat_hold_vld", vld4, 1);
      chk("sat_hold_cnt", cnt4, 15);
      chk("sat_hold_ovf", ovf4, 1);
    end
    ready4 = 1'b1;
    tick();
    chk("sat_vld_drop", vld4, 0);
    chk("sat_cnt_keep", cnt4, 15);
    chk("sat_busy_drop", busy4, 0);

    // Abort mid-COUNT at T+50, then a normal measurement
    win_len = 16'd100; start = 1'b1;
    for (int n = 1; n <= 49; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    chk("abort_pre_pd", pd, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pd", pd, 1);
    chk("abort_busy", busy, 0);
    chk("abort_vld", vld, 0);
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("abort_no_vld", vld, 0);
    end
    start = 1'b1;
    for (int n = 1; n <= 109; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    chk("reabort_vld", vld, 1);
    chk("reabort_cnt_range", (cnt >= 16'd9 && cnt <= 16'd11) ? 1 : 0, 1);
    tick();
    chk("reabort_vld_drop", vld, 0);

    // start while busy is ignored (window length not relatched)
    win_len = 16'd20; start = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      tick();
      start = 1'b0;
      if (n == 3) begin
        win_len = 16'd5;
        start = 1'b1;
      end
      chk("busy_start_vld", vld, (n == 29) ? 1 : 0);
    end
    chk("busy_start_cnt_range", (cnt >= 16'd1 && cnt <= 16'd3) ? 1 : 0, 1);
    tick();
    chk("busy_start_drop", vld, 0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_pd", pd, 1);
    tick();
    chk("start_abort_busy2", busy, 0);

    // Reset mid-COUNT
    win_len = 16'd100; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) start = 1'b0;
    end
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_pd", pd, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_vld", vld, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_ovf", ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
